alu_wb_buffer: RTL and testbench
================================

ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

Interface
REQ-001 Parameter DATA_W, 24, result/writeback data width.
REQ-002 Parameter ADDR_W, 4, register address width (16 registers).
REQ-003 Parameter DEPTH, 2, buffer entries; power of two, 2..8.
REQ-004 Clock  in  1  sole clock, rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 InValid  in  1  execute stage (shifter/ALU) presents a result.
REQ-007 InReady  out  1  buffer accepts; high iff not full.
REQ-008 InResult  in  DATA_W  result word (e.g. shift result).
REQ-009 InRd  in  ADDR_W  destination register.
REQ-010 InRegWrite  in  1  result is to be written.
REQ-011 WbValid  out  1  head entry present.
REQ-012 WbReady  in  1  register-file write port free.
REQ-013 WbData  out  DATA_W  head data.
REQ-014 WbAddr  out  ADDR_W  head destination.
REQ-015 WbWrite  out  1  qualified write strobe = WbValid & head write flag.
REQ-016 Count  out  clog2(DEPTH)+1  occupied entries.
REQ-017 Rs1Addr, Rs2Addr  in  ADDR_W each  decode read addresses (forwarding only).
REQ-018 Fwd1Hit, Fwd2Hit  out  1 each; Fwd1Data, Fwd2Data  out  DATA_W each (forwarding only).

Function
REQ-019 Enqueue SHALL occur on a rising edge with InValid & InReady; dequeue with WbValid & WbReady.
REQ-020 InReady SHALL depend only on registered state (Count != DEPTH); no combinational path from WbReady.
REQ-021 Full buffer SHALL reject input even when draining that cycle; Count goes DEPTH -> DEPTH-1.
REQ-022 Simultaneous enqueue and dequeue on non-empty, non-full buffer SHALL leave Count unchanged and preserve order.
REQ-023 Enqueue on empty buffer SHALL give WbValid=1 the next cycle (latency 1); no same-cycle bypass.
REQ-024 Occupancy state SHALL be EMPTY (Count=0), PARTIAL, FULL (Count=DEPTH); transitions only by REQ-019 events, one step per cycle.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.
REQ-026 Entries with InRd=0 SHALL be stored with write flag cleared (register 0 is constant zero).
REQ-027 When empty, WbData and WbAddr SHALL be 0 and WbWrite 0.
REQ-028 Entries with write flag 0 SHALL still occupy a slot and dequeue normally.
REQ-029 Dequeue while empty and enqueue while full SHALL be ignored without state change.

Reset
REQ-030 Reset low SHALL asynchronously clear pointers, Count, all write flags; InReady=1, WbValid=0, WbWrite=0, WbData=0, WbAddr=0, Fwd*Hit=0.
REQ-031 Reset mid-operation SHALL discard all buffered entries; first edge after release accepts input.

Configuration
REQ-032 Macro ALU_WB_FWD_EN: defined -> forwarding ports and logic present; undefined -> Rs*/Fwd* ports absent, no compare logic.
REQ-033 With ALU_WB_FWD_EN, FwdNHit SHALL be high iff a valid entry has write flag 1 and address equal to RsNAddr (nonzero); FwdNData SHALL be the youngest matching entry, else 0; purely combinational from stored state.

Structure
REQ-034 Shared package SHALL hold DATA_W/ADDR_W defaults and the occupancy-state enum (EMPTY, PARTIAL, FULL).
REQ-035 One sub-module, wb_fwd_match, SHALL implement per-port youngest-match selection, instantiated twice.

Verification
REQ-036 Reset; enqueue 0x000800 to r3; next cycle WbValid=1, WbAddr=3, WbData=0x000800, WbWrite=1; WbReady=1 -> Count 0.
REQ-037 WbReady=0, three pushes (0x1,0x2,0x3): first two accepted, InReady=0 at Count=2, third held; release -> drains 0x1,0x2,0x3 in order.
REQ-038 Count=1, push and pop same cycle for 10 cycles -> Count stays 1, output order matches input order.
REQ-039 Push to r0 with 0xFFFFFF -> entry dequeues with WbWrite=0, Fwd hit on Rs1Addr=0 never asserted.
REQ-040 (ALU_WB_FWD_EN) push r5=0xA, then r5=0xB, Rs1Addr=5 -> Fwd1Hit=1, Fwd1Data=0xB; after both drain Fwd1Hit=0.
REQ-041 Full buffer, Reset pulsed low mid-cycle -> outputs clear immediately, Count=0, InReady=1 before next edge.

Source files
------------

// File: rtl/alu_wb_buffer_pkg.sv
// Shared defaults and occupancy-state type for the ALU writeback buffer.
package alu_wb_buffer_pkg;

    localparam int ALU_DATA_W = 24;  // result / writeback word width
    localparam int ALU_ADDR_W = 4;   // register address width (16 registers)

    // Occupancy of the writeback buffer.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_e;

endpackage

// File: rtl/alu_wb_buffer_fwd.sv
// wb_fwd_match: youngest-entry match of one decode read address against the
// buffered writeback entries. Pure combinational; instantiated per read port.
module wb_fwd_match #(
    parameter  int DATA_W = 24,
    parameter  int ADDR_W = 4,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
    input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
    input  logic [DEPTH-1:0]             ent_wflag,
    input  logic [PTR_W-1:0]             rd_ptr,
    input  logic [PTR_W:0]               count,
    input  logic [ADDR_W-1:0]            rs_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    // Walk oldest -> youngest so the last (youngest) match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && ent_wflag[idx] &&
                (ent_addr[idx] == rs_addr) && (rs_addr != '0)) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: small FIFO between the execute stage and the register-file
// write port. InReady depends on registered occupancy only, so a full buffer
// refuses input even in a cycle where it drains.
// Optional feature: define ALU_WB_FWD_EN to add the Rs*/Fwd* forwarding ports.
module alu_wb_buffer
    import alu_wb_buffer_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int ADDR_W = ALU_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [DATA_W-1:0]         InResult,
    input  logic [ADDR_W-1:0]         InRd,
    input  logic                      InRegWrite,
    output logic                      WbValid,
    input  logic                      WbReady,
    output logic [DATA_W-1:0]         WbData,
    output logic [ADDR_W-1:0]         WbAddr,
    output logic                      WbWrite,
`ifdef ALU_WB_FWD_EN
    input  logic [ADDR_W-1:0]         Rs1Addr,
    input  logic [ADDR_W-1:0]         Rs2Addr,
    output logic                      Fwd1Hit,
    output logic                      Fwd2Hit,
    output logic [DATA_W-1:0]         Fwd1Data,
    output logic [DATA_W-1:0]         Fwd2Data,
`endif
    output logic [$clog2(DEPTH):0]    Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    occ_e                        occ_q, occ_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0]            wflag_q, wflag_d;

    logic push, pop, in_ready, wb_valid;

    assign in_ready = (occ_q != FULL);
    assign wb_valid = (occ_q != EMPTY);
    assign push     = InValid & in_ready;
    assign pop      = wb_valid & WbReady;

    assign InReady = in_ready;
    assign WbValid = wb_valid;
    assign Count   = count_q;
    // Head fields are forced to zero while empty so stale slots never leak.
    assign WbData  = wb_valid ? data_q[rd_ptr_q] : '0;
    assign WbAddr  = wb_valid ? addr_q[rd_ptr_q] : '0;
    assign WbWrite = wb_valid & wflag_q[rd_ptr_q];

    // Occupancy FSM: one step per cycle, driven only by accepted push/pop.
    always_comb begin
        occ_d = occ_q;
        case (occ_q)
            EMPTY: if (push) occ_d = PARTIAL;
            PARTIAL: begin
                if (push && !pop && count_q == CNT_W'(DEPTH - 1)) occ_d = FULL;
                else if (pop && !push && count_q == CNT_W'(1))    occ_d = EMPTY;
            end
            FULL: if (pop) occ_d = PARTIAL;
            default: occ_d = EMPTY;
        endcase
    end

    // Pointer, count and entry storage updates.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        addr_d   = addr_q;
        wflag_d  = wflag_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // push and pop never hit the same slot: that needs empty or full.
        if (pop) begin
            wflag_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            data_d[wr_ptr_q]  = InResult;
            addr_d[wr_ptr_q]  = InRd;
            // r0 is hardwired zero: keep the slot but never write it.
            wflag_d[wr_ptr_q] = InRegWrite & (InRd != '0);
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
    end

    // State registers; reset discards every buffered entry.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            occ_q    <= EMPTY;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            wflag_q  <= '0;
        end else begin
            occ_q    <= occ_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            wflag_q  <= wflag_d;
        end
    end

`ifdef ALU_WB_FWD_EN
    wb_fwd_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd1 (
        .ent_data (data_q),
        .ent_addr (addr_q),
        .ent_wflag(wflag_q),
        .rd_ptr   (rd_ptr_q),
        .count    (count_q),
        .rs_addr  (Rs1Addr),
        .hit      (Fwd1Hit),
        .data     (Fwd1Data)
    );

    wb_fwd_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd2 (
        .ent_data (data_q),
        .ent_addr (addr_q),
        .ent_wflag(wflag_q),
        .rd_ptr   (rd_ptr_q),
        .count    (count_q),
        .rs_addr  (Rs2Addr),
        .hit      (Fwd2Hit),
        .data     (Fwd2Data)
    );
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed bench for alu_wb_buffer (DEPTH=2). Forwarding checks compile in
// only when ALU_WB_FWD_EN is defined.
module tb_alu_wb_buffer;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              InValid, InReady, InRegWrite;
    logic [DATA_W-1:0] InResult;
    logic [ADDR_W-1:0] InRd;
    logic              WbValid, WbReady, WbWrite;
    logic [DATA_W-1:0] WbData;
    logic [ADDR_W-1:0] WbAddr;
    logic [$clog2(DEPTH):0] Count;
`ifdef ALU_WB_FWD_EN
    logic [ADDR_W-1:0] Rs1Addr, Rs2Addr;
    logic              Fwd1Hit, Fwd2Hit;
    logic [DATA_W-1:0] Fwd1Data, Fwd2Data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    alu_wb_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .InResult  (InResult),
        .InRd      (InRd),
        .InRegWrite(InRegWrite),
        .WbValid   (WbValid),
        .WbReady   (WbReady),
        .WbData    (WbData),
        .WbAddr    (WbAddr),
        .WbWrite   (WbWrite),
`ifdef ALU_WB_FWD_EN
        .Rs1Addr   (Rs1Addr),
        .Rs2Addr   (Rs2Addr),
        .Fwd1Hit   (Fwd1Hit),
        .Fwd2Hit   (Fwd2Hit),
        .Fwd1Data  (Fwd1Data),
        .Fwd2Data  (Fwd2Data),
`endif
        .Count     (Count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                         input logic [ADDR_W-1:0] rd, input logic we);
        InValid    = v;
        InResult   = d;
        InRd       = rd;
        InRegWrite = we;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        Reset   = 1'b0;
        WbReady = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
`ifdef ALU_WB_FWD_EN
        Rs1Addr = '0;
        Rs2Addr = '0;
`endif
        #12;
        chk("rst_inready", InReady, 1);
        chk("rst_wbvalid", WbValid, 0);
        chk("rst_wbdata",  WbData,  0);
        chk("rst_wbaddr",  WbAddr,  0);
        chk("rst_wbwrite", WbWrite, 0);
        chk("rst_count",   Count,   0);
        @(negedge Clock);
        Reset = 1'b1;
        step();

        // Dequeue on empty buffer is ignored.
        WbReady = 1'b1;
        step();
        chk("empty_pop_count", Count, 0);
        WbReady = 1'b0;

        // Single push, latency one, then drain.
        drive(1'b1, 24'h000800, 4'd3, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        chk("p1_wbvalid", WbValid, 1);
        chk("p1_wbaddr",  WbAddr,  3);
        chk("p1_wbdata",  WbData,  32'h800);
        chk("p1_wbwrite", WbWrite, 1);
        chk("p1_count",   Count,   1);
        WbReady = 1'b1;
        step();
        chk("p1_drain_count", Count,   0);
        chk("p1_drain_valid", WbValid, 0);
        chk("p1_drain_data",  WbData,  0);

        // Fill to full with writeback stalled; third push is held.
        WbReady = 1'b0;
        drive(1'b1, 24'h1, 4'd1, 1'b1);
        step();
        chk("f1_count",   Count,   1);
        chk("f1_inready", InReady, 1);
        drive(1'b1, 24'h2, 4'd2, 1'b1);
        step();
        chk("f2_count",   Count,   2);
        chk("f2_inready", InReady, 0);
        drive(1'b1, 24'h3, 4'd3, 1'b1);
        step();
        chk("f3_held_count", Count,  2);
        chk("f3_head",       WbData, 1);
        // Release: full buffer drains but still refuses this cycle.
        WbReady = 1'b1;
        step();
        chk("rel1_count", Count,  1);
        chk("rel1_head",  WbData, 2);
        step();
        chk("rel2_count", Count,  1);
        chk("rel2_head",  WbData, 3);
        drive(1'b0, '0, '0, 1'b0);
        step();
        chk("rel3_count", Count, 0);

        // Count=1 steady state: push and pop every cycle.
        WbReady = 1'b0;
        drive(1'b1, 24'd100, 4'd4, 1'b1);
        step();
        chk("ss_init_count", Count, 1);
        WbReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 24'(101 + k), 4'd4, 1'b1);
            step();
            chk("ss_count", Count, 1);
            chk("ss_head",  WbData, 32'(101 + k));
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
        chk("ss_drain_count", Count, 0);

        // Write to r0 occupies a slot but never writes or forwards.
        WbReady = 1'b0;
        drive(1'b1, 24'hFFFFFF, 4'd0, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        chk("r0_valid", WbValid, 1);
        chk("r0_write", WbWrite, 0);
        chk("r0_data",  WbData,  32'hFFFFFF);
`ifdef ALU_WB_FWD_EN
        Rs1Addr = 4'd0;
        #1;
        chk("r0_fwd1hit", Fwd1Hit, 0);
`endif
        WbReady = 1'b1;
        step();
        chk("r0_drain_count", Count, 0);

        // Non-writing entry to r7 still dequeues normally.
        WbReady = 1'b0;
        drive(1'b1, 24'h777, 4'd7, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        chk("nw_valid", WbValid, 1);
        chk("nw_addr",  WbAddr,  7);
        chk("nw_write", WbWrite, 0);
        WbReady = 1'b1;
        step();
        chk("nw_drain_count", Count, 0);

`ifdef ALU_WB_FWD_EN
        // Youngest-match forwarding.
        WbReady = 1'b0;
        Rs1Addr = 4'd5;
        Rs2Addr = 4'd3;
        drive(1'b1, 24'hA, 4'd5, 1'b1);
        step();
        chk("fwd_a_hit",  Fwd1Hit,  1);
        chk("fwd_a_data", Fwd1Data, 32'hA);
        drive(1'b1, 24'hB, 4'd5, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        chk("fwd_b_hit",   Fwd1Hit,  1);
        chk("fwd_b_data",  Fwd1Data, 32'hB);
        chk("fwd2_miss",   Fwd2Hit,  0);
        chk("fwd2_data0",  Fwd2Data, 0);
        WbReady = 1'b1;
        step();
        chk("fwd_d1_hit",  Fwd1Hit,  1);
        chk("fwd_d1_data", Fwd1Data, 32'hB);
        step();
        chk("fwd_d2_hit",  Fwd1Hit,  0);
        chk("fwd_d2_data", Fwd1Data, 0);
`endif

        // Asynchronous reset of a full buffer mid-cycle.
        WbReady = 1'b0;
        drive(1'b1, 24'h11, 4'd1, 1'b1);
        step();
        drive(1'b1, 24'h22, 4'd2, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        chk("ar_full_count", Count, 2);
        #2;
        Reset = 1'b0;
        #1;
        chk("ar_count",   Count,   0);
        chk("ar_inready", InReady, 1);
        chk("ar_wbvalid", WbValid, 0);
        chk("ar_wbdata",  WbData,  0);
        chk("ar_wbwrite", WbWrite, 0);
        #1;
        Reset = 1'b1;
        drive(1'b1, 24'h55, 4'd2, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        chk("ar_post_count", Count,  1);
        chk("ar_post_data",  WbData, 32'h55);
        chk("ar_post_addr",  WbAddr, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
